// File: rtl/tonos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tonos_pkg
//  Description : Shared definitions for the music-box tone generator: the
//                chromatic note table C6..B6, the half-period helper and the
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tonos_pkg;

  // Largest keyboard the note table can serve.
  localparam int unsigned MAX_KEYS = 12;

  // Chromatic note frequencies in Hz, C6 up to B6.
  localparam int unsigned NOTE_HZ [0:11] = '{
    1046, 1108, 1174, 1244, 1318, 1396,
    1479, 1567, 1661, 1760, 1864, 1975
  };

  // Player states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } estado_t;

  // Clock cycles per half period of a tone, truncated.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned hz);
    return clk_hz / (2 * hz);
  endfunction

endpackage
`default_nettype wire

// File: rtl/antirrebote.sv
`default_nettype none
// ============================================================================
//  Module      : antirrebote
//  Description : Two-flop synchroniser followed by a shared debounce counter.
//                The debounced vector takes the synchronised pattern once that
//                pattern has stayed unchanged for DEBOUNCE_CYC cycles; any
//                change in the pattern restarts the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module antirrebote #(
  parameter int unsigned WIDTH        = 12,
  parameter int unsigned DEBOUNCE_CYC = 50_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned   DW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] CNT_MAX = DW'(DEBOUNCE_CYC - 1);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] deb_q,  deb_d;
  logic [DW-1:0]    cnt_q,  cnt_d;

  // Synchroniser shift and stability counting; a difference between the two
  // synchroniser stages means a new pattern is arriving, so the count restarts.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (meta_q != sync_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = sync_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      deb_q  <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = deb_q;

endmodule
`default_nettype wire

// File: rtl/generador_tonos.sv
`default_nettype none
// ============================================================================
//  Module      : generador_tonos
//  Description : Multi-key square-wave tone generator. Debounced keys are
//                priority encoded (lowest index wins) and a single shared
//                half-period counter produces the tone. Note changes and
//                release only happen at a falling edge of clk_out, so no runt
//                pulses are produced.
//  Options     : TONE_OCTAVE_EN - adds the octava port; the half period is
//                shifted right by octava (floor of 1 cycle), sampled at the
//                same boundaries as note changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module generador_tonos
  import tonos_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned N_KEYS       = 12,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEBOUNCE_CYC = 50_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] teclas,
`ifdef TONE_OCTAVE_EN
  input  logic [1:0]        octava,
`endif
  output logic              clk_out,
  output logic [3:0]        nota_activa,
  output logic              sonando
);

  // --------------------------------------------------------------------------
  // Elaboration-time sanity checks
  // --------------------------------------------------------------------------
  if ((N_KEYS < 1) || (N_KEYS > MAX_KEYS)) begin : g_chk_keys
    $error("generador_tonos: N_KEYS must be in 1..12");
  end

  if (64'(half_period(CLK_HZ, NOTE_HZ[0])) > ((64'd1 << CNT_W) - 64'd1)) begin : g_chk_cnt
    $error("generador_tonos: CNT_W too narrow for the lowest note half period");
  end

  // --------------------------------------------------------------------------
  // Half-period table, constant after elaboration. Padded to 16 entries so a
  // 4-bit note index can address it directly.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] half_tab [16];

  for (genvar k = 0; k < 16; k++) begin : g_half
    if (k < N_KEYS) begin : g_used
      assign half_tab[k] = CNT_W'(half_period(CLK_HZ, NOTE_HZ[k]));
    end else begin : g_unused
      assign half_tab[k] = CNT_W'(1);
    end
  end

  // Counter reload value: shifted half period, never below one cycle, minus one
  // because the phase ends on the cycle the counter is seen at zero.
  function automatic logic [CNT_W-1:0] reload_val(input logic [CNT_W-1:0] half,
                                                  input logic [1:0]       oct);
    logic [CNT_W-1:0] eff;
    eff = half >> oct;
    if (eff == '0) begin
      eff = CNT_W'(1);
    end
    return eff - 1'b1;
  endfunction

  // --------------------------------------------------------------------------
  // Key conditioning
  // --------------------------------------------------------------------------
  logic [N_KEYS-1:0] deb;

  antirrebote #(
    .WIDTH        (N_KEYS),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_antirrebote (
    .clk   (clk),
    .reset (reset),
    .din   (teclas),
    .dout  (deb)
  );

  logic [1:0] oct_in;
`ifdef TONE_OCTAVE_EN
  assign oct_in = octava;
`else
  assign oct_in = 2'd0;
`endif

  // Priority encoder: scanning downwards lets the lowest pressed key win.
  logic [3:0] sel;
  logic       req;

  always_comb begin
    sel = 4'd0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (deb[i]) begin
        sel = 4'(i);
      end
    end
  end

  assign req = |deb;

  // --------------------------------------------------------------------------
  // Player FSM with the shared half-period counter
  // --------------------------------------------------------------------------
  estado_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             clk_q,   clk_d;
  logic [3:0]       nota_q,  nota_d;
  logic [1:0]       oct_q,   oct_d;

  // Next-state logic: the key request is only re-evaluated at phase
  // boundaries, so a running phase always completes at its loaded length.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    nota_d  = nota_q;
    oct_d   = oct_q;
    case (state_q)
      ST_IDLE: begin
        clk_d = 1'b0;
        if (req) begin
          state_d = ST_PLAY;
          nota_d  = sel;
          oct_d   = oct_in;
          cnt_d   = reload_val(half_tab[sel], oct_in);
          clk_d   = 1'b1;
        end
      end

      ST_PLAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!clk_q) begin
          // Rising toggle: same note, same octave.
          clk_d = 1'b1;
          cnt_d = reload_val(half_tab[nota_q], oct_q);
        end else begin
          // Falling toggle: the only place a note may change or stop.
          clk_d = 1'b0;
          if (!req) begin
            state_d = ST_RELEASE;
            cnt_d   = reload_val(half_tab[nota_q], oct_q);
          end else begin
            nota_d = sel;
            oct_d  = oct_in;
            cnt_d  = reload_val(half_tab[sel], oct_in);
          end
        end
      end

      ST_RELEASE: begin
        clk_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (req) begin
          // Key came back during the final low phase: resume on the rise.
          state_d = ST_PLAY;
          nota_d  = sel;
          oct_d   = oct_in;
          cnt_d   = reload_val(half_tab[sel], oct_in);
          clk_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
          nota_d  = 4'd0;
          oct_d   = 2'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
        nota_d  = 4'd0;
        oct_d   = 2'd0;
      end
    endcase
  end

  // Player state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      nota_q  <= 4'd0;
      oct_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      nota_q  <= nota_d;
      oct_q   <= oct_d;
    end
  end

  assign clk_out     = clk_q;
  assign nota_activa = nota_q;
  assign sonando     = (state_q == ST_PLAY) || (state_q == ST_RELEASE);

endmodule
`default_nettype wire

// File: tb/tb_generador_tonos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_generador_tonos
//  Description : Self-checking bench for generador_tonos with CLK_HZ=2_092_000
//                and DEBOUNCE_CYC=4 (HALF[0]=1000, HALF[1]=944, HALF[2]=890).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_generador_tonos;

  localparam int unsigned CLK_HZ = 2_092_000;
  localparam int unsigned N_KEYS = 12;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEB    = 4;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [11:0] teclas = 12'h000;
`ifdef TONE_OCTAVE_EN
  logic [1:0]  octava = 2'd0;
`endif
  logic        clk_out;
  logic [3:0]  nota_activa;
  logic        sonando;

  generador_tonos #(
    .CLK_HZ       (CLK_HZ),
    .N_KEYS       (N_KEYS),
    .CNT_W        (CNT_W),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .teclas      (teclas),
`ifdef TONE_OCTAVE_EN
    .octava      (octava),
`endif
    .clk_out     (clk_out),
    .nota_activa (nota_activa),
    .sonando     (sonando)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    teclas = 12'h000;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  // Count clocks until clk_out reaches lvl (bounded by lim).
  task automatic wait_level(input logic lvl, input int lim, output int n);
    n = 0;
    while (n < lim) begin
      tick();
      n++;
      if (clk_out == lvl) break;
    end
  endtask

  // Measure a high phase, changing the keys 'at' cycles into it.
  task automatic high_with_change(input logic [11:0] nuevo, input int at, output int n);
    n = 0;
    while (n < 4000) begin
      tick();
      n++;
      if (n == at) teclas = nuevo;
      if (!clk_out) break;
    end
  endtask

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    int          lat;
    int          high1;
    int          low1;
    int          high2;
    int          nota;
  } vec_t;

  vec_t tabla [4];

  initial begin
    int n;
    int m;
    int bad;

    tabla[0] = '{12'h001, 12'h001, 7, 1000, 1000, 1000, 0};
    tabla[1] = '{12'h001, 12'h005, 7, 1000, 1000, 1000, 0};
    tabla[2] = '{12'h001, 12'h004, 7, 1000,  890,  890, 2};
    tabla[3] = '{12'h002, 12'h003, 7,  944, 1000, 1000, 0};

    // Reset with every key pressed: outputs stay quiet during and after reset.
    reset  = 1'b1;
    teclas = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", {clk_out, sonando, nota_activa}, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post_reset", {clk_out, sonando, nota_activa}, 0);
    end
    teclas = 12'h000;
    bad = 0;
    repeat (20) begin
      tick();
      if (clk_out || sonando) bad++;
    end
    check("post_reset_quiet", bad, 0);

    // Table-driven note sequences.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      teclas = tabla[i].a;
      wait_level(1'b1, 50, n);
      check($sformatf("v%0d_latency", i), n, tabla[i].lat);
      check($sformatf("v%0d_sonando", i), int'(sonando), 1);
      high_with_change(tabla[i].b, 300, n);
      check($sformatf("v%0d_high1", i), n, tabla[i].high1);
      check($sformatf("v%0d_nota", i), int'(nota_activa), tabla[i].nota);
      wait_level(1'b1, 4000, n);
      check($sformatf("v%0d_low1", i), n, tabla[i].low1);
      wait_level(1'b0, 4000, n);
      check($sformatf("v%0d_high2", i), n, tabla[i].high2);
    end

    // Release mid-high: high completes, one full low phase, then idle.
    do_reset();
    teclas = 12'h001;
    wait_level(1'b1, 50, n);
    high_with_change(12'h000, 300, n);
    check("rel_high", n, 1000);
    m   = 0;
    bad = 0;
    while (m < 3000) begin
      tick();
      m++;
      if (clk_out) bad++;
      if (!sonando) break;
    end
    check("rel_low_len", m, 1000);
    check("rel_low_clean", bad, 0);
    check("rel_nota", int'(nota_activa), 0);
    bad = 0;
    repeat (20) begin
      tick();
      if (clk_out || sonando) bad++;
    end
    check("rel_idle", bad, 0);

    // Key comes back during the release low phase with a different note.
    do_reset();
    teclas = 12'h001;
    wait_level(1'b1, 50, n);
    high_with_change(12'h000, 300, n);
    m = 0;
    while (m < 3000) begin
      tick();
      m++;
      if (m == 200) teclas = 12'h004;
      if (clk_out) break;
    end
    check("rearm_low", m, 1000);
    check("rearm_nota", int'(nota_activa), 2);
    check("rearm_sonando", int'(sonando), 1);
    wait_level(1'b0, 4000, n);
    check("rearm_high", n, 890);

    // Reset during a tone silences the output on the next edge.
    reset = 1'b1;
    tick();
    check("reset_mid_tone", {clk_out, sonando, nota_activa}, 0);

    // A three-cycle glitch never gets through the debouncer.
    do_reset();
    teclas = 12'h001;
    repeat (3) tick();
    teclas = 12'h000;
    bad = 0;
    repeat (30) begin
      tick();
      if (clk_out || sonando) bad++;
    end
    check("glitch", bad, 0);

`ifdef TONE_OCTAVE_EN
    // One octave up halves the phases of key 0.
    do_reset();
    octava = 2'd1;
    teclas = 12'h001;
    wait_level(1'b1, 50, n);
    check("oct_latency", n, 7);
    wait_level(1'b0, 4000, n);
    check("oct_high", n, 500);
    wait_level(1'b1, 4000, n);
    check("oct_low", n, 500);
    octava = 2'd0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
